bounce_gen: RTL and testbench



---
 rtl/bounce_gen_pkg.sv | 16 +
 rtl/lfsr16.sv | 27 ++
 rtl/bounce_gen.sv | 122 ++++++++++++
 tb/tb_bounce_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/bounce_gen_pkg.sv
// Shared types and constants for the bouncy-button stimulus generator.
package bounce_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam int unsigned LFSR_W   = 16;
  localparam int unsigned SETTLE_W = 16;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR with clock gate; low OUT_W bits exposed.
module lfsr16
  import bounce_gen_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
  parameter int unsigned       OUT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cg,
  output logic [OUT_W-1:0] o_lfsr
);

  logic [LFSR_W-1:0] r_lfsr;

  // Right-shifting Galois step; state only moves on enabled cycles
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lfsr <= SEED;
    end else if (i_cg) begin
      r_lfsr <= {1'b0, r_lfsr[LFSR_W-1:1]} ^ (r_lfsr[0] ? LFSR_TAPS : '0);
    end
  end

  assign o_lfsr = r_lfsr[OUT_W-1:0];

endmodule

// File: rtl/bounce_gen.sv
// Turns clean press/release commands into a bouncy button line that
// settles at the requested level for a guaranteed hold time.
module bounce_gen
  import bounce_gen_pkg::*;
#(
  parameter int unsigned       BOUNCE_W      = 4,
  parameter int unsigned       GLITCH_W      = 4,
  parameter int unsigned       SETTLE_CYCLES = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cg,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_level,
  input  logic [BOUNCE_W-1:0] i_nBounce,
  output logic                o_button,
  output logic                o_busy,
  output logic                o_done
);

  localparam int unsigned          TOG_W       = BOUNCE_W + 2;
  localparam logic [SETTLE_W-1:0]  SETTLE_INIT = SETTLE_W'(SETTLE_CYCLES - 1);

  state_t                r_state;
  logic [TOG_W-1:0]      r_toggles;
  logic [GLITCH_W-1:0]   r_glitch;
  logic [SETTLE_W-1:0]   r_settle;
  logic                  r_button;
  logic                  r_busy;
  logic                  r_done;

  logic [GLITCH_W-1:0]   w_glitch_seed;
  logic [TOG_W-1:0]      w_toggles_init;
  logic                  w_accept;

  // Random glitch durations come from the low LFSR bits
  lfsr16 #(
    .SEED  (LFSR_SEED),
    .OUT_W (GLITCH_W)
  ) u_lfsr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_cg   (i_cg),
    .o_lfsr (w_glitch_seed)
  );

  // Ready drops during the done cycle so back-to-back commands get a gap
  assign o_ready        = (r_state == IDLE) & i_cg & ~r_done;
  assign w_accept       = i_valid & o_ready;
  assign w_toggles_init = TOG_W'({i_nBounce, 1'b1});

  // Command FSM: odd toggle count guarantees the line ends at the target
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_toggles <= '0;
      r_glitch  <= '0;
      r_settle  <= '0;
      r_button  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (i_cg) begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_busy <= 1'b1;
            if (i_level == r_button) begin
              r_state  <= SETTLE;
              r_settle <= SETTLE_INIT;
            end else begin
              r_button <= ~r_button;
              r_glitch <= w_glitch_seed;
              if (i_nBounce == '0) begin
                r_state   <= SETTLE;
                r_settle  <= SETTLE_INIT;
                r_toggles <= '0;
              end else begin
                r_state   <= BOUNCE;
                r_toggles <= w_toggles_init - TOG_W'(1);
              end
            end
          end
        end
        BOUNCE: begin
          if (r_glitch != '0) begin
            r_glitch <= r_glitch - GLITCH_W'(1);
          end else begin
            r_button  <= ~r_button;
            r_toggles <= r_toggles - TOG_W'(1);
            if (r_toggles == TOG_W'(1)) begin
              r_state  <= SETTLE;
              r_settle <= SETTLE_INIT;
            end else begin
              r_glitch <= w_glitch_seed;
            end
          end
        end
        SETTLE: begin
          if (r_settle != '0) begin
            r_settle <= r_settle - SETTLE_W'(1);
          end else begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_button = r_button;
  assign o_busy   = r_busy;
  assign o_done   = r_done;

endmodule

// File: tb/tb_bounce_gen.sv
// Self-checking bench for bounce_gen: directed table, hand-written
// reset/clock-gate sequences and randomized commands against a
// transaction-level model of toggle times and completion.
module tb_bounce_gen;

  localparam int S = 16;

  logic       clk = 1'b0;
  logic       rst, cg, valid, level;
  logic [3:0] nb;
  logic       ready, button, busy, done;

  int errors = 0;
  int checks = 0;
  int act    = 0;      // enabled, non-reset edges since last reset
  logic m_button = 1'b0;
  logic [15:0] seq [0:32767];

  typedef struct {
    logic lvl;
    int   n;
    int   exp_tog;
    int   exp_lat;
    bit   keep;
  } vec_t;

  always #5 clk = ~clk;

  bounce_gen dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_cg      (cg),
    .i_valid   (valid),
    .o_ready   (ready),
    .i_level   (level),
    .i_nBounce (nb),
    .o_button  (button),
    .o_busy    (busy),
    .o_done    (done)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) act = 0;
    else if (cg) act++;
    #1;
  endtask

  // Issue one command and check every cycle until one cycle past done.
  // cg_mode: 0 none, 1 gate off 10 cycles mid-settle, 2 gate off on done cycle.
  task automatic run_cmd(input logic lvl, input int n, input int cg_mode,
                         input bit keep_valid, input int exp_tog, input int exp_lat);
    int   tg[$];
    int   a, dn, t, ntog, cg_at, wall, wd, obs_tog, w, frozen;
    logic b0, prev, eb;
    valid = 1'b1;
    level = lvl;
    nb    = 4'(n);
    w = 0;
    while (ready !== 1'b1 && w < 40) begin
      tick();
      w++;
    end
    chk("ready_before_accept", ready, 1);
    if (ready !== 1'b1) begin
      valid = 1'b0;
      return;
    end
    a  = act;
    b0 = m_button;
    tg.delete();
    if (lvl != b0) begin
      t = a;
      for (int i = 0; i < 2 * n + 1; i++) begin
        tg.push_back(t);
        t = t + int'(seq[t & 32767][3:0]) + 1;
      end
      dn = tg[$] + S;
    end else begin
      dn = a + S;
    end
    cg_at   = (cg_mode == 1) ? dn - 8 : (cg_mode == 2) ? dn : -1;
    frozen  = (cg_mode == 1) ? 10 : 0;
    wall    = 0;
    wd      = -1;
    obs_tog = 0;
    prev    = button;
    for (int k = a; k <= dn + 1; k++) begin
      tick();
      wall++;
      if (k == a) begin
        valid = keep_valid;
        level = 1'($urandom);
        nb    = 4'($urandom);
      end
      if (button !== prev) obs_tog++;
      prev = button;
      ntog = 0;
      foreach (tg[i]) if (tg[i] <= k) ntog++;
      eb = b0 ^ ntog[0];
      if (k == dn) wd = wall;
      chk("button", button, eb);
      chk("busy", busy, k < dn);
      chk("done", done, k == dn);
      chk("ready", ready, k > dn);
      if (k == cg_at) begin
        cg = 1'b0;
        for (int j = 0; j < 10; j++) begin
          tick();
          wall++;
          if (button !== prev) obs_tog++;
          prev = button;
          chk("gated_button", button, eb);
          chk("gated_done", done, k == dn);
          chk("gated_busy", busy, k < dn);
          chk("gated_ready", ready, 0);
        end
        cg = 1'b1;
      end
    end
    chk("toggle_count", obs_tog, (exp_tog >= 0) ? exp_tog : ((lvl != b0) ? 2 * n + 1 : 0));
    if (exp_lat >= 0) chk("done_latency", wd - 1, exp_lat + frozen);
    else              chk("done_latency", wd - 1, dn - a + frozen);
    m_button = lvl;
  endtask

  task automatic idle_cycles(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      tick();
      chk("idle_button", button, m_button);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_ready", ready, 1);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [8];
    seq[0] = 16'hACE1;
    for (int i = 1; i < 32768; i++)
      seq[i] = {1'b0, seq[i-1][15:1]} ^ (seq[i-1][0] ? 16'hB400 : 16'h0000);

    // Starting from o_button=1 after the reset-abort sequence
    vecs[0] = '{1'b0,  0,  1, S,  1'b0};
    vecs[1] = '{1'b1,  3,  7, -1, 1'b0};
    vecs[2] = '{1'b1,  5,  0, S,  1'b0};
    vecs[3] = '{1'b0,  5, 11, -1, 1'b0};
    vecs[4] = '{1'b0,  5,  0, S,  1'b0};
    vecs[5] = '{1'b1, 15, 31, -1, 1'b1};
    vecs[6] = '{1'b0, 15, 31, -1, 1'b1};
    vecs[7] = '{1'b1,  2,  5, -1, 1'b0};

    rst = 1'b1; cg = 1'b1; valid = 1'b0; level = 1'b0; nb = '0;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_button", button, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", ready, 1);
    rst = 1'b0;

    // Reset mid-bounce while the line is high
    valid = 1'b1; level = 1'b1; nb = 4'd15;
    tick();
    valid = 1'b0;
    chk("first_toggle", button, 1);
    chk("first_busy", busy, 1);
    rst = 1'b1;
    tick();
    chk("abort_button", button, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", ready, 1);
    rst = 1'b0;
    m_button = 1'b0;
    run_cmd(1'b1, 15, 0, 1'b0, 31, -1);

    foreach (vecs[i]) begin
      run_cmd(vecs[i].lvl, vecs[i].n, 0, vecs[i].keep, vecs[i].exp_tog, vecs[i].exp_lat);
      if (!vecs[i].keep) idle_cycles(2);
    end

    // Clock gate frozen mid-settle, then across the done pulse
    run_cmd(1'b0, 2, 1, 1'b0, 5, -1);
    idle_cycles(1);
    run_cmd(1'b1, 0, 2, 1'b0, 1, S);
    idle_cycles(1);
    run_cmd(1'b1, 4, 1, 1'b0, 0, S);
    idle_cycles(1);

    // Randomized commands
    for (int r = 0; r < 30; r++) begin
      logic rl;
      int   rn, rm;
      bit   rk;
      rl = 1'($urandom_range(0, 1));
      rn = $urandom_range(0, 15);
      rm = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
      rk = (r != 29) && ($urandom_range(0, 1) == 1);
      run_cmd(rl, rn, rm, rk, -1, -1);
      if (!rk) idle_cycles($urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
